mem_arbiter: RTL and testbench

Two-master, one-slave arbiter for the shared 32-bit memory bus. It lets the CPU core and a second requester, such as a loader or debug port, share a single memory/interconnect port. Arbitration is round-robin on each accepted transfer. The block records the master ID of every accepted read in order, so `read_data_valid` beats return to the master that issued them. The request path adds zero cycles; all state lives in the priority register and the return-ID queue.

---
 rtl/mem_bus_pkg.sv | 9 +
 rtl/id_fifo.sv | 56 +++++
 rtl/mem_arbiter.sv | 107 ++++++++++
 tb/tb_mem_arbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and widths for the 32-bit memory bus.
//   master_id_t : 1-bit requester ID (0 = CPU core, 1 = second master)
//   MEM_*_W     : address, data and byte-enable widths
package mem_bus_pkg;
  typedef logic [0:0] master_id_t;
  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_BE_W   = 4;
endpackage

// File: rtl/id_fifo.sv
// Synchronous FIFO with registered count.
//   push_i/wdata_i : enqueue (ignored when full)
//   pop_i          : dequeue (ignored when empty)
//   head_o         : oldest entry, valid when !empty_o
//   count_o/full_o/empty_o : occupancy from the registered count
// DEPTH must be a power of two so the pointers wrap on their own.
module id_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == DEPTH[AW:0]);
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      // simultaneous push+pop leaves the count untouched
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // storage needs no reset; entries are only read once written
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter onto one memory slave port.
//   m0_*/m1_* : master request ports (addr, data, byte enables, rd/wr req)
//               with ready and read-return outputs
//   s_*       : slave port; s_read_data is broadcast back to both masters
//   error     : sticky, set by a read beat with nothing outstanding
// Request/grant/ready and read-return paths are purely combinational;
// the only state is the last-grant bit, the return-ID FIFO and error.
module mem_arbiter
  import mem_bus_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  m0_ready,
  input  logic [MEM_ADDR_W-1:0] m0_addr,
  input  logic [MEM_DATA_W-1:0] m0_write_data,
  input  logic [MEM_BE_W-1:0]   m0_byte_enable,
  input  logic                  m0_write_req,
  input  logic                  m0_read_req,
  output logic [MEM_DATA_W-1:0] m0_read_data,
  output logic                  m0_read_data_valid,
  output logic                  m1_ready,
  input  logic [MEM_ADDR_W-1:0] m1_addr,
  input  logic [MEM_DATA_W-1:0] m1_write_data,
  input  logic [MEM_BE_W-1:0]   m1_byte_enable,
  input  logic                  m1_write_req,
  input  logic                  m1_read_req,
  output logic [MEM_DATA_W-1:0] m1_read_data,
  output logic                  m1_read_data_valid,
  input  logic                  s_ready,
  output logic [MEM_ADDR_W-1:0] s_addr,
  output logic [MEM_DATA_W-1:0] s_write_data,
  output logic [MEM_BE_W-1:0]   s_byte_enable,
  output logic                  s_write_req,
  output logic                  s_read_req,
  input  logic [MEM_DATA_W-1:0] s_read_data,
  input  logic                  s_read_data_valid,
  output logic                  error
);
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  master_id_t     last_grant_q, last_grant_d, grant, head;
  logic           error_q, error_d;
  logic           req0, req1, gnt_rd, gnt_wr, read_blocked;
  logic           accept, push, pop, full, empty;
  logic [CW-1:0]  count;

  assign req0 = m0_write_req | m0_read_req;
  assign req1 = m1_write_req | m1_read_req;

  // on a tie the master that did not win last is chosen; idle defaults to 0
  always_comb begin
    grant = '0;
    if (req0 && req1) grant = ~last_grant_q;
    else if (req1)    grant = 1'b1;
  end

  assign gnt_rd       = grant[0] ? m1_read_req  : m0_read_req;
  assign gnt_wr       = grant[0] ? m1_write_req : m0_write_req;
  // full is taken from the registered count, so a same-cycle pop does not help
  assign read_blocked = gnt_rd & full;

  assign s_addr        = grant[0] ? m1_addr        : m0_addr;
  assign s_write_data  = grant[0] ? m1_write_data  : m0_write_data;
  assign s_byte_enable = grant[0] ? m1_byte_enable : m0_byte_enable;
  assign s_write_req   = ~reset & gnt_wr;
  assign s_read_req    = ~reset & gnt_rd & ~read_blocked;

  assign m0_ready = ~reset & s_ready & (grant == 1'b0) & req0 & ~read_blocked;
  assign m1_ready = ~reset & s_ready & (grant == 1'b1) & req1 & ~read_blocked;

  assign accept = m0_ready | m1_ready;
  assign push   = accept & gnt_rd;
  assign pop    = ~reset & s_read_data_valid & ~empty;

  id_fifo #(.WIDTH(1), .DEPTH(MAX_OUTSTANDING)) u_ret_q (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (grant),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign m0_read_data       = s_read_data;
  assign m1_read_data       = s_read_data;
  assign m0_read_data_valid = pop & (head == 1'b0);
  assign m1_read_data_valid = pop & (head == 1'b1);

  assign last_grant_d = accept ? grant : last_grant_q;
  assign error_d      = error_q | (s_read_data_valid & empty);
  assign error        = error_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;  // master 0 wins the first tie
      error_q      <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      error_q      <= error_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  logic        clk = 1'b0, reset;
  logic        m0_ready, m1_ready, m0_read_data_valid, m1_read_data_valid;
  logic [31:0] m0_addr, m0_write_data, m1_addr, m1_write_data;
  logic [3:0]  m0_byte_enable, m1_byte_enable;
  logic        m0_write_req, m0_read_req, m1_write_req, m1_read_req;
  logic [31:0] m0_read_data, m1_read_data;
  logic        s_ready, s_write_req, s_read_req, s_read_data_valid, error;
  logic [31:0] s_addr, s_write_data, s_read_data;
  logic [3:0]  s_byte_enable;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_OUTSTANDING(4)) dut (
    .clk(clk), .reset(reset),
    .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_write_data(m0_write_data),
    .m0_byte_enable(m0_byte_enable), .m0_write_req(m0_write_req), .m0_read_req(m0_read_req),
    .m0_read_data(m0_read_data), .m0_read_data_valid(m0_read_data_valid),
    .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_write_data(m1_write_data),
    .m1_byte_enable(m1_byte_enable), .m1_write_req(m1_write_req), .m1_read_req(m1_read_req),
    .m1_read_data(m1_read_data), .m1_read_data_valid(m1_read_data_valid),
    .s_ready(s_ready), .s_addr(s_addr), .s_write_data(s_write_data),
    .s_byte_enable(s_byte_enable), .s_write_req(s_write_req), .s_read_req(s_read_req),
    .s_read_data(s_read_data), .s_read_data_valid(s_read_data_valid), .error(error)
  );

  // inputs change on negedge; outputs are sampled 1ns later, well before posedge
  task automatic idle();
    m0_addr = '0; m0_write_data = '0; m0_byte_enable = 4'hF; m0_write_req = 0; m0_read_req = 0;
    m1_addr = '0; m1_write_data = '0; m1_byte_enable = 4'hF; m1_write_req = 0; m1_read_req = 0;
    s_ready = 0; s_read_data = '0; s_read_data_valid = 0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(); idle(); reset = 1;
    m0_read_req = 1; s_ready = 1; s_read_data_valid = 1;
    #1;
    checks++; if (m0_ready !== 1'b0) begin failures++; $display("FAIL rst_m0_ready act=%b exp=0", m0_ready); end
    checks++; if (s_read_req !== 1'b0) begin failures++; $display("FAIL rst_s_read_req act=%b exp=0", s_read_req); end
    checks++; if (m0_read_data_valid !== 1'b0 || m1_read_data_valid !== 1'b0) begin failures++; $display("FAIL rst_valid act=%b%b exp=00", m0_read_data_valid, m1_read_data_valid); end
    step(); idle(); reset = 0; #1;
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL rst_error act=%b exp=0", error); end
    checks++; if (dut.count !== 3'd0) begin failures++; $display("FAIL rst_count act=%0d exp=0", dut.count); end
  endtask

  task automatic test_single_reads();
    logic [31:0] addrs [2];
    logic [31:0] data  [2];
    addrs[0] = 32'h1000_0000; addrs[1] = 32'h1000_0004;
    data[0]  = 32'hDEAD_BEEF; data[1]  = 32'h1234_5678;
    for (int i = 0; i < 2; i++) begin
      step(); idle(); s_ready = 1; m0_read_req = 1; m0_addr = addrs[i]; #1;
      checks++; if (m0_ready !== 1'b1 || s_read_req !== 1'b1 || s_addr !== addrs[i]) begin failures++; $display("FAIL single_req%0d act=rdy%b req%b addr%h exp=rdy1 req1 addr%h", i, m0_ready, s_read_req, s_addr, addrs[i]); end
    end
    step(); idle(); #1;
    checks++; if (dut.count !== 3'd2) begin failures++; $display("FAIL single_count2 act=%0d exp=2", dut.count); end
    step(); step();
    for (int i = 0; i < 2; i++) begin
      step(); idle(); s_read_data_valid = 1; s_read_data = data[i]; #1;
      checks++; if (m0_read_data_valid !== 1'b1 || m1_read_data_valid !== 1'b0 || m0_read_data !== data[i]) begin failures++; $display("FAIL single_beat%0d act=v%b%b d%h exp=v10 d%h", i, m0_read_data_valid, m1_read_data_valid, m0_read_data, data[i]); end
    end
    step(); idle(); #1;
    checks++; if (dut.count !== 3'd0) begin failures++; $display("FAIL single_count0 act=%0d exp=0", dut.count); end
  endtask

  task automatic test_contention();
    logic exp_g;
    step(); idle(); reset = 1;
    step(); reset = 0;
    for (int i = 0; i < 4; i++) begin
      exp_g = i[0];
      idle(); s_ready = 1;
      m0_read_req = 1; m0_addr = 32'h100 + 32'(i);
      m1_read_req = 1; m1_addr = 32'h200 + 32'(i);
      #1;
      checks++; if (m0_ready !== ~exp_g || m1_ready !== exp_g || s_addr !== (exp_g ? m1_addr : m0_addr)) begin failures++; $display("FAIL contend_grant%0d act=rdy%b%b addr%h exp_grant=m%0d", i, m0_ready, m1_ready, s_addr, exp_g); end
      step();
    end
    idle(); #1;
    checks++; if (dut.count !== 3'd4) begin failures++; $display("FAIL contend_count act=%0d exp=4", dut.count); end
    for (int i = 0; i < 4; i++) begin
      step(); idle(); s_read_data_valid = 1; s_read_data = 32'hA0 + 32'(i); #1;
      exp_g = i[0];
      checks++; if (m0_read_data_valid !== ~exp_g || m1_read_data_valid !== exp_g) begin failures++; $display("FAIL contend_route%0d act=v%b%b exp_master=m%0d", i, m0_read_data_valid, m1_read_data_valid, exp_g); end
    end
    step(); idle();
  endtask

  task automatic test_stall();
    // last accepted was m1, so a tie now grants m0
    for (int i = 0; i < 5; i++) begin
      idle(); s_ready = 0;
      m0_write_req = 1; m0_addr = 32'h300; m0_write_data = 32'h1111_0000;
      m1_write_req = 1; m1_addr = 32'h400; m1_write_data = 32'h2222_0000;
      #1;
      checks++; if (s_addr !== 32'h300 || m0_ready !== 1'b0 || m1_ready !== 1'b0 || s_write_req !== 1'b1) begin failures++; $display("FAIL stall_hold%0d act=addr%h rdy%b%b wr%b exp=addr300 rdy00 wr1", i, s_addr, m0_ready, m1_ready, s_write_req); end
      step();
    end
    s_ready = 1; #1;
    checks++; if (m0_ready !== 1'b1 || m1_ready !== 1'b0 || s_write_data !== 32'h1111_0000) begin failures++; $display("FAIL stall_release act=rdy%b%b wd%h exp=rdy10 wd11110000", m0_ready, m1_ready, s_write_data); end
    step(); idle();
  endtask

  task automatic test_queue_full();
    for (int i = 0; i < 4; i++) begin
      idle(); s_ready = 1; m0_read_req = 1; m0_addr = 32'h500 + 32'(4*i); #1;
      checks++; if (m0_ready !== 1'b1) begin failures++; $display("FAIL full_fill%0d act=%b exp=1", i, m0_ready); end
      step();
    end
    idle(); s_ready = 1; m0_read_req = 1; m0_addr = 32'h510; #1;
    checks++; if (s_read_req !== 1'b0 || m0_ready !== 1'b0) begin failures++; $display("FAIL full_block act=req%b rdy%b exp=req0 rdy0", s_read_req, m0_ready); end
    step(); s_read_data_valid = 1; s_read_data = 32'h5; #1;
    checks++; if (m0_ready !== 1'b0 || m0_read_data_valid !== 1'b1) begin failures++; $display("FAIL full_pop_block act=rdy%b v%b exp=rdy0 v1", m0_ready, m0_read_data_valid); end
    step(); s_read_data_valid = 0; #1;
    checks++; if (m0_ready !== 1'b1 || s_read_req !== 1'b1) begin failures++; $display("FAIL full_accept5 act=rdy%b req%b exp=rdy1 req1", m0_ready, s_read_req); end
    for (int i = 0; i < 4; i++) begin
      step(); idle(); s_read_data_valid = 1; #1;
      checks++; if (m0_read_data_valid !== 1'b1 || m1_read_data_valid !== 1'b0) begin failures++; $display("FAIL full_drain%0d act=v%b%b exp=v10", i, m0_read_data_valid, m1_read_data_valid); end
    end
    step(); idle(); #1;
    checks++; if (dut.count !== 3'd0) begin failures++; $display("FAIL full_count0 act=%0d exp=0", dut.count); end
  endtask

  task automatic test_mixed();
    idle(); s_ready = 1; m0_read_req = 1; m0_addr = 32'h40; #1;
    checks++; if (m0_ready !== 1'b1) begin failures++; $display("FAIL mixed_rd act=%b exp=1", m0_ready); end
    step(); idle(); s_ready = 1;
    m1_write_req = 1; m1_addr = 32'h20; m1_write_data = 32'hCAFE_F00D; m1_byte_enable = 4'h3; #1;
    checks++; if (m1_ready !== 1'b1 || s_write_req !== 1'b1 || s_read_req !== 1'b0 || s_addr !== 32'h20 || s_write_data !== 32'hCAFE_F00D || s_byte_enable !== 4'h3) begin failures++; $display("FAIL mixed_wr act=rdy%b wr%b rd%b a%h d%h be%h exp=rdy1 wr1 rd0 a20 dcafef00d be3", m1_ready, s_write_req, s_read_req, s_addr, s_write_data, s_byte_enable); end
    step(); idle(); #1;
    checks++; if (dut.count !== 3'd1) begin failures++; $display("FAIL mixed_count act=%0d exp=1", dut.count); end
    s_read_data_valid = 1; s_read_data = 32'h55AA; #1;
    checks++; if (m0_read_data_valid !== 1'b1 || m1_read_data_valid !== 1'b0 || m0_read_data !== 32'h55AA) begin failures++; $display("FAIL mixed_route act=v%b%b d%h exp=v10 d55aa", m0_read_data_valid, m1_read_data_valid, m0_read_data); end
    step(); idle();
  endtask

  task automatic test_spurious_reset();
    // leave last_grant at m0 so a missing reset of it would grant m1 on the tie
    idle(); s_ready = 1; m0_write_req = 1; #1;
    checks++; if (m0_ready !== 1'b1) begin failures++; $display("FAIL spur_prewrite act=%b exp=1", m0_ready); end
    step(); idle(); s_read_data_valid = 1; #1;
    checks++; if (m0_read_data_valid !== 1'b0 || m1_read_data_valid !== 1'b0) begin failures++; $display("FAIL spur_valid act=v%b%b exp=v00", m0_read_data_valid, m1_read_data_valid); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL spur_err_pre act=%b exp=0", error); end
    step(); idle(); #1;
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL spur_err_set act=%b exp=1", error); end
    step(); #1;
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL spur_err_sticky act=%b exp=1", error); end
    reset = 1; step(); reset = 0; #1;
    checks++; if (error !== 1'b0 || dut.count !== 3'd0) begin failures++; $display("FAIL spur_reset act=err%b cnt%0d exp=err0 cnt0", error, dut.count); end
    s_ready = 1; m0_read_req = 1; m1_read_req = 1; #1;
    checks++; if (m0_ready !== 1'b1 || m1_ready !== 1'b0) begin failures++; $display("FAIL spur_tie act=rdy%b%b exp=rdy10", m0_ready, m1_ready); end
    step(); idle();
  endtask

  initial begin
    idle(); reset = 1;
    repeat (2) @(posedge clk);
    test_reset();
    test_single_reads();
    test_contention();
    test_stall();
    test_queue_full();
    test_mixed();
    test_spurious_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
